mux3to1: RTL and testbench
==========================

Name: mux3to1

Overview:
- Parameterised 3-to-1 data selector used as the PC-source mux in the fetch stage.
- Choices: sequential PC+4 (in0), jump target (in1), branch target (in2).
- Provides a combinational output for same-cycle next-PC use and a registered copy with a valid flag.
- Also provides illegal-select detection and saturating per-source selection counters for debug and performance observation.

Parameters:
- WIDTH, 32, data width of in0/in1/in2/out/out_q.
- CNT_W, 16, width of each selection counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- in0  input  WIDTH  source 0 (sequential PC+4).
- in1  input  WIDTH  source 1 (jump address).
- in2  input  WIDTH  source 2 (branch address).
- sel  input  2  source select: 0→in0, 1→in1, 2→in2, 3→illegal.
- in_valid  input  1  current sel/inputs are a real selection event.
- err_clr  input  1  clears sel_err_sticky.
- cnt_clr  input  1  clears cnt0/cnt1/cnt2.
- out  output  WIDTH  combinational selected value.
- out_q  output  WIDTH  registered selected value.
- out_valid  output  1  registered in_valid.
- sel_err  output  1  one-cycle registered flag: previous valid cycle had sel=3.
- sel_err_sticky  output  1  latched illegal-select indicator.
- cnt0  output  CNT_W  count of valid selections of in0.
- cnt1  output  CNT_W  count of valid selections of in1.
- cnt2  output  CNT_W  count of valid selections of in2.

Behaviour:
- out is purely combinational with zero latency and is independent of clk, rst and in_valid.
  - sel=0 → in0; sel=1 → in1; sel=2 → in2.
  - sel=3 → in0 (safe fall-through to sequential PC).
  - sel containing X/Z → in0.
- Reset (rst=0, asynchronous, applied immediately without waiting for a clock edge):
  - out_q=0, out_valid=0, sel_err=0, sel_err_sticky=0, cnt0=cnt1=cnt2=0.
  - out still follows the combinational select during reset.
- Reset deassertion takes effect at the first rising clk edge with rst=1.
- Each rising edge with rst=1:
  - out_q <= out, every cycle regardless of in_valid; latency 1.
  - out_valid <= in_valid.
  - sel_err <= in_valid & (sel==3).
  - sel_err_sticky: set when in_valid & (sel==3); otherwise cleared when err_clr=1; otherwise holds. Set wins over err_clr in the same cycle.
  - Counters: when in_valid=1 and sel=k (k in 0..2), cntk increments by 1.
    - Saturates at 2^CNT_W-1; no wrap-around.
    - sel=3 increments no counter.
    - in_valid=0 increments nothing.
  - cnt_clr=1 zeroes all three counters and takes priority over a same-cycle increment.
- No handshake back-pressure: the block accepts every cycle.
- Reset asserted mid-operation discards all state asynchronously; no partial updates.
- Inputs are unsigned bit vectors; no arithmetic on data paths.

Test Plan:
- Combinational select: in0=32'h00000004, in1=32'h00000100, in2=32'h00000200.
  - sel=0/1/2/3 → out=0x04/0x100/0x200/0x04, settling with no clock edge.
- Async reset: run with in_valid=1, sel=1 for 3 cycles, then drop rst between edges.
  - out_q, out_valid, counters and flags go 0 immediately.
  - After rst=1 and one edge, out_q=selected value and out_valid=1.
- Registered path: in_valid=1, sel=2, in2=0xDEADBEEF.
  - out_q=0xDEADBEEF and out_valid=1 one edge later.
  - in_valid=0 next cycle → out_valid=0; out_q still tracks out.
- Illegal select: in_valid=1, sel=3 for one cycle.
  - sel_err=1 for exactly one cycle; sel_err_sticky=1 and stays.
  - err_clr=1 with sel=0 → sticky=0.
  - err_clr=1 together with valid sel=3 → sticky stays 1.
- Counters: 5 valid cycles sel=0, 2 with sel=1, 1 with sel=2, 1 with sel=3, 2 with in_valid=0.
  - Result: cnt0=5, cnt1=2, cnt2=1.
  - cnt_clr=1 with valid sel=0 in same cycle → all counters 0.
- Saturation (CNT_W=2): 6 valid sel=1 cycles → cnt1 reaches 3 and holds at 3.

Source files
------------

// File: rtl/mux3to1.sv
// PC-source selector for the fetch stage: combinational and registered outputs,
// illegal-select flags and saturating per-source selection counters.
module mux3to1 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    input  logic             err_clr,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid,
    output logic             sel_err,
    output logic             sel_err_sticky,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic             sel_illegal;

    // Anything other than 1 or 2 (including 3 and unknowns) falls back to PC+4.
    always_comb begin
        out = in0;
        case (sel)
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in0;
        endcase
    end

    assign sel_illegal = in_valid && (sel == 2'd3);

    always_comb begin
        data_d   = out;
        valid_d  = in_valid;
        err_d    = sel_illegal;
        sticky_d = sticky_q;
        if (sel_illegal) begin
            sticky_d = 1'b1;
        end else if (err_clr) begin
            sticky_d = 1'b0;
        end
    end

    // Clear beats increment; increments stop at all-ones.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            cnt_d[k] = cnt_q[k];
            if (cnt_clr) begin
                cnt_d[k] = '0;
            end else if (in_valid && (sel == 2'(k)) && (cnt_q[k] != CNT_MAX)) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            for (int k = 0; k < 3; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign out_q          = data_q;
    assign out_valid      = valid_q;
    assign sel_err        = err_q;
    assign sel_err_sticky = sticky_q;
    assign cnt0           = cnt_q[0];
    assign cnt1           = cnt_q[1];
    assign cnt2           = cnt_q[2];

endmodule

// File: tb/tb_mux3to1.sv
// Bench for mux3to1: directed scenarios plus randomized traffic against a
// behavioural model; a second instance with 2-bit counters exercises saturation.
module tb_mux3to1;

    logic        clk;
    logic        rst;
    logic [31:0] in0, in1, in2;
    logic [1:0]  sel;
    logic        in_valid, err_clr, cnt_clr;

    logic [31:0] out, out_q;
    logic        out_valid, sel_err, sel_err_sticky;
    logic [15:0] cnt0, cnt1, cnt2;

    logic [31:0] s_out, s_out_q;
    logic        s_out_valid, s_sel_err, s_sel_err_sticky;
    logic [1:0]  s_cnt0, s_cnt1, s_cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    logic [31:0] exp_out_q;
    logic        exp_valid, exp_err, exp_sticky;
    int          exp_cnt [3];
    int          exp_sat [3];

    mux3to1 #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in2(in2), .sel(sel),
        .in_valid(in_valid), .err_clr(err_clr), .cnt_clr(cnt_clr),
        .out(out), .out_q(out_q), .out_valid(out_valid), .sel_err(sel_err),
        .sel_err_sticky(sel_err_sticky), .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2)
    );

    mux3to1 #(.WIDTH(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in2(in2), .sel(sel),
        .in_valid(in_valid), .err_clr(err_clr), .cnt_clr(cnt_clr),
        .out(s_out), .out_q(s_out_q), .out_valid(s_out_valid), .sel_err(s_sel_err),
        .sel_err_sticky(s_sel_err_sticky), .cnt0(s_cnt0), .cnt1(s_cnt1), .cnt2(s_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mux(input logic [1:0] s);
        if (s == 2'd1) return in1;
        if (s == 2'd2) return in2;
        return in0;
    endfunction

    task automatic model_reset();
        exp_out_q  = '0;
        exp_valid  = 1'b0;
        exp_err    = 1'b0;
        exp_sticky = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_cnt[k] = 0;
            exp_sat[k] = 0;
        end
    endtask

    task automatic model_step();
        bit illegal;
        illegal   = in_valid && (sel == 2'd3);
        exp_out_q = ref_mux(sel);
        exp_valid = in_valid;
        exp_err   = illegal;
        if (illegal) exp_sticky = 1'b1;
        else if (err_clr) exp_sticky = 1'b0;
        if (cnt_clr) begin
            for (int k = 0; k < 3; k++) begin
                exp_cnt[k] = 0;
                exp_sat[k] = 0;
            end
        end else if (in_valid && sel != 2'd3) begin
            exp_cnt[sel] = (exp_cnt[sel] + 1 > 65535) ? 65535 : exp_cnt[sel] + 1;
            exp_sat[sel] = (exp_sat[sel] + 1 > 3) ? 3 : exp_sat[sel] + 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [1:0] s, input logic ec, input logic cc);
        in_valid = v;
        sel      = s;
        err_clr  = ec;
        cnt_clr  = cc;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({out_q, out_valid, sel_err, sel_err_sticky, cnt0, cnt1, cnt2} !== '0) begin
            $display("FAIL reset_state: out_q=%h valid=%b err=%b sticky=%b cnt=%0d/%0d/%0d required all zero",
                     out_q, out_valid, sel_err, sel_err_sticky, cnt0, cnt1, cnt2);
        end else n_pass++;
        $display("test_reset: out_q=%h out_valid=%b", out_q, out_valid);
    endtask

    task automatic test_comb_select();
        logic [31:0] req [4];
        req[0] = 32'h4; req[1] = 32'h100; req[2] = 32'h200; req[3] = 32'h4;
        in0 = 32'h4; in1 = 32'h100; in2 = 32'h200;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            n_checks++;
            if (out !== req[s]) $display("FAIL comb_sel%0d: out=%h required %h", s, out, req[s]);
            else n_pass++;
            $display("test_comb_select: sel=%0d out=%h", s, out);
        end
    endtask

    task automatic test_async_reset();
        in1 = 32'h0000_1234;
        set_in(1, 3, 0, 0);
        tick();
        set_in(1, 1, 0, 0);
        repeat (3) tick();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({out_q, out_valid, sel_err, sel_err_sticky, cnt0, cnt1, cnt2} !== '0) begin
            $display("FAIL async_reset: out_q=%h valid=%b err=%b sticky=%b cnt=%0d/%0d/%0d required all zero",
                     out_q, out_valid, sel_err, sel_err_sticky, cnt0, cnt1, cnt2);
        end else n_pass++;
        n_checks++;
        if (out !== 32'h0000_1234) $display("FAIL out_in_reset: out=%h required 00001234", out);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_checks++;
        if (out_q !== 32'h0000_1234 || out_valid !== 1'b1 || cnt1 !== 16'd1) begin
            $display("FAIL reset_release: out_q=%h valid=%b cnt1=%0d required 00001234/1/1",
                     out_q, out_valid, cnt1);
        end else n_pass++;
        $display("test_async_reset: out_q=%h out_valid=%b cnt1=%0d", out_q, out_valid, cnt1);
    endtask

    task automatic test_registered();
        in2 = 32'hDEAD_BEEF;
        set_in(1, 2, 0, 0);
        tick();
        n_checks++;
        if (out_q !== 32'hDEAD_BEEF || out_valid !== 1'b1)
            $display("FAIL reg_valid: out_q=%h valid=%b required deadbeef/1", out_q, out_valid);
        else n_pass++;
        in0 = 32'h0000_0A08;
        set_in(0, 0, 0, 0);
        tick();
        n_checks++;
        if (out_q !== 32'h0000_0A08 || out_valid !== 1'b0)
            $display("FAIL reg_invalid: out_q=%h valid=%b required 00000a08/0", out_q, out_valid);
        else n_pass++;
        $display("test_registered: out_q=%h out_valid=%b", out_q, out_valid);
    endtask

    task automatic test_illegal_select();
        set_in(1, 3, 0, 0);
        tick();
        n_checks++;
        if (sel_err !== 1'b1 || sel_err_sticky !== 1'b1)
            $display("FAIL illegal_set: err=%b sticky=%b required 1/1", sel_err, sel_err_sticky);
        else n_pass++;
        set_in(1, 0, 0, 0);
        tick();
        n_checks++;
        if (sel_err !== 1'b0 || sel_err_sticky !== 1'b1)
            $display("FAIL illegal_hold: err=%b sticky=%b required 0/1", sel_err, sel_err_sticky);
        else n_pass++;
        set_in(1, 0, 1, 0);
        tick();
        n_checks++;
        if (sel_err_sticky !== 1'b0)
            $display("FAIL err_clr: sticky=%b required 0", sel_err_sticky);
        else n_pass++;
        set_in(1, 3, 1, 0);
        tick();
        n_checks++;
        if (sel_err !== 1'b1 || sel_err_sticky !== 1'b1)
            $display("FAIL set_beats_clr: err=%b sticky=%b required 1/1", sel_err, sel_err_sticky);
        else n_pass++;
        set_in(0, 0, 1, 0);
        tick();
        $display("test_illegal_select: err=%b sticky=%b", sel_err, sel_err_sticky);
    endtask

    task automatic test_counters();
        set_in(0, 0, 0, 1);
        tick();
        set_in(1, 0, 0, 0); repeat (5) tick();
        set_in(1, 1, 0, 0); repeat (2) tick();
        set_in(1, 2, 0, 0); tick();
        set_in(1, 3, 0, 0); tick();
        set_in(0, 1, 0, 0); repeat (2) tick();
        n_checks++;
        if (cnt0 !== 16'd5 || cnt1 !== 16'd2 || cnt2 !== 16'd1)
            $display("FAIL counters: cnt=%0d/%0d/%0d required 5/2/1", cnt0, cnt1, cnt2);
        else n_pass++;
        $display("test_counters: cnt=%0d/%0d/%0d", cnt0, cnt1, cnt2);
        set_in(1, 0, 0, 1);
        tick();
        n_checks++;
        if (cnt0 !== 16'd0 || cnt1 !== 16'd0 || cnt2 !== 16'd0)
            $display("FAIL cnt_clr_priority: cnt=%0d/%0d/%0d required 0/0/0", cnt0, cnt1, cnt2);
        else n_pass++;
        $display("test_counters: after clr cnt=%0d/%0d/%0d", cnt0, cnt1, cnt2);
    endtask

    task automatic test_saturation();
        set_in(0, 0, 0, 1);
        tick();
        set_in(1, 1, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_checks++;
            if (s_cnt1 !== 2'((i > 3) ? 3 : i))
                $display("FAIL saturate_%0d: cnt1=%0d required %0d", i, s_cnt1, (i > 3) ? 3 : i);
            else n_pass++;
            $display("test_saturation: step %0d cnt1=%0d", i, s_cnt1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in0      = $urandom;
            in1      = $urandom;
            in2      = $urandom;
            sel      = 2'($urandom_range(0, 3));
            in_valid = 1'($urandom_range(0, 1));
            err_clr  = ($urandom_range(0, 3) == 0);
            cnt_clr  = ($urandom_range(0, 15) == 0);
            #1;
            n_checks++;
            if (out !== ref_mux(sel))
                $display("FAIL rand_out[%0d]: out=%h required %h", i, out, ref_mux(sel));
            else n_pass++;
            tick();
            n_checks++;
            if (out_q !== exp_out_q || out_valid !== exp_valid || sel_err !== exp_err ||
                sel_err_sticky !== exp_sticky || cnt0 !== 16'(exp_cnt[0]) ||
                cnt1 !== 16'(exp_cnt[1]) || cnt2 !== 16'(exp_cnt[2]) ||
                s_cnt0 !== 2'(exp_sat[0]) || s_cnt1 !== 2'(exp_sat[1]) || s_cnt2 !== 2'(exp_sat[2])) begin
                $display("FAIL rand_state[%0d]: got q=%h v=%b e=%b s=%b c=%0d/%0d/%0d sc=%0d/%0d/%0d required q=%h v=%b e=%b s=%b c=%0d/%0d/%0d sc=%0d/%0d/%0d",
                         i, out_q, out_valid, sel_err, sel_err_sticky, cnt0, cnt1, cnt2,
                         s_cnt0, s_cnt1, s_cnt2, exp_out_q, exp_valid, exp_err, exp_sticky,
                         exp_cnt[0], exp_cnt[1], exp_cnt[2], exp_sat[0], exp_sat[1], exp_sat[2]);
            end else n_pass++;
            if (i % 50 == 0)
                $display("test_random: cycle %0d sel=%0d valid=%b out_q=%h", i, sel, in_valid, out_q);
        end
    endtask

    initial begin
        rst = 1'b0;
        in0 = '0; in1 = '0; in2 = '0;
        set_in(0, 0, 0, 0);
        model_reset();
        test_reset();
        test_comb_select();
        @(negedge clk);
        rst = 1'b1;
        test_async_reset();
        test_registered();
        test_illegal_select();
        test_counters();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
